input_debounce: RTL
===================

INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter SW_W, default 24: number of switch channels.
REQ-002 SHALL have parameter BT_W, default 8: number of button channels.
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 50: consecutive stable cycles required to accept a change; legal range 2..65535.
REQ-004 SHALL have parameter REPEAT_DELAY, default 5000: cycles of hold before the first auto-repeat pulse.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 1000: cycles between later auto-repeat pulses.
REQ-006 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port power  input  1: reset, asynchronous, active-low.
REQ-008 SHALL have port sw  input  SW_W: raw asynchronous switch levels.
REQ-009 SHALL have port bt  input  BT_W: raw asynchronous button levels, 1 = pressed.
REQ-010 SHALL have port switch  output  SW_W: debounced switch levels, registered.
REQ-011 SHALL have port button  output  BT_W: debounced button levels, registered.
REQ-012 SHALL have port bt_press  output  BT_W: per-button one-cycle press strobe, registered.
REQ-013 SHALL have port sw_changed  output  1: one-cycle strobe, any switch bit changed, registered.

Function
REQ-014 SHALL pass every sw and bt bit through its own two-flop synchronizer before any other logic.
REQ-015 SHALL give each of the SW_W+BT_W channels an independent debouncer: state IDLE (synced == output, count 0) or COUNT (synced != output).
REQ-016 SHALL, in COUNT, increment the channel count each cycle the synced bit differs from the output; on the cycle the synced bit equals the output again, SHALL clear the count and return to IDLE.
REQ-017 SHALL, when a differing channel's count equals DEBOUNCE_CYC-1, load the synced value into the output bit, clear the count and go to IDLE.
REQ-018 Timing: the output SHALL follow a raw change held stable at least DEBOUNCE_CYC+2 cycles exactly DEBOUNCE_CYC+2 rising edges after the first sampling edge.
REQ-019 SHALL leave the output unchanged for any glitch shorter than DEBOUNCE_CYC synced cycles; the count restarts from 0 after each glitch.
REQ-020 SHALL size the count counter to ceil(log2(DEBOUNCE_CYC)) bits; the counter SHALL never wrap.
REQ-021 SHALL assert sw_changed for exactly the cycle after any switch output bit changes; simultaneous changes on several bits SHALL give one pulse.
REQ-022 SHALL assert bt_press[i] for exactly the cycle after button[i] goes 0->1; a 1->0 change SHALL give no strobe.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL each be handled the same as they would be alone.

Reset
REQ-024 SHALL, while power=0, asynchronously force all synchronizer flops, counts, switch, button, bt_press, sw_changed and repeat counters to 0; all debouncers SHALL be in IDLE.
REQ-025 SHALL, when power=0 arrives mid-count, discard the count; after release, a raw input held at 1 SHALL be debounced from scratch, and for a button SHALL give a bt_press strobe.
REQ-026 SHALL take its first sample on the first rising edge of clk after power goes to 1.

Configuration
REQ-027 With macro INPUT_DEBOUNCE_AUTOREPEAT_EN defined: while button[i] stays 1, SHALL pulse bt_press[i] again REPEAT_DELAY cycles after the press strobe, then every REPEAT_PERIOD cycles; release SHALL stop repeats and clear the repeat counter at once.
REQ-028 Without INPUT_DEBOUNCE_AUTOREPEAT_EN: SHALL give exactly one bt_press strobe per debounced press; REPEAT_DELAY and REPEAT_PERIOD SHALL have no effect and no repeat logic SHALL be built.

Verification (bench parameters: SW_W=4, BT_W=2, DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-029 SHALL cover: sw=4'b0101 held from edge 0 -> switch=4'b0101 at edge 6; sw_changed=1 on edge 7 only.
REQ-030 SHALL cover: bt[0] high for 3 cycles, then low -> button and bt_press stay 0 throughout.
REQ-031 SHALL cover: bt[1] held high -> button[1]=1 at edge 6, bt_press[1]=1 on edge 7 only; release -> button[1]=0 six edges later with no strobe.
REQ-032 SHALL cover: bt[0] held 40 cycles, with the macro defined -> bt_press[0] pulses at edges 7, 17, 22, 27, 32, ...; without the macro -> edge 7 only.
REQ-033 SHALL cover: sw[2] rises, power pulsed low at edge 3 for 1 cycle while sw[2] stays high -> switch=0 during reset, switch[2]=1 six edges after power release.
REQ-034 SHALL cover: sw[0] and bt[0] both change on the same edge -> switch[0] and button[0] update on the same edge; one sw_changed pulse and one bt_press[0] pulse.

Source files
------------

// File: rtl/input_debounce.sv
// input_debounce -- per-channel debouncer for switches and buttons.
//
// Every raw switch and button bit is double-flop synchronized, then filtered
// by its own two-state debouncer (IDLE / COUNT). A change is accepted only
// after the synced bit has differed from the current output for
// DEBOUNCE_CYC consecutive cycles. The output then follows the raw input
// DEBOUNCE_CYC+2 edges after the first sampling edge.
//
// Optional feature macro: INPUT_DEBOUNCE_AUTOREPEAT_EN
//   When defined, a held button re-strobes bt_press REPEAT_DELAY cycles after
//   the press strobe, and then every REPEAT_PERIOD cycles.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   power      in   asynchronous active-low reset
//   sw         in   [SW_W] raw switch levels
//   bt         in   [BT_W] raw button levels, 1 = pressed
//   switch     out  [SW_W] debounced switch levels
//   button     out  [BT_W] debounced button levels
//   bt_press   out  [BT_W] one-cycle press strobe per button
//   sw_changed out  one-cycle strobe, any debounced switch bit changed
module input_debounce #(
  parameter int unsigned SW_W          = 24,
  parameter int unsigned BT_W          = 8,
  parameter int unsigned DEBOUNCE_CYC  = 50,
  parameter int unsigned REPEAT_DELAY  = 5000,
  parameter int unsigned REPEAT_PERIOD = 1000
) (
  input  logic            clk,
  input  logic            power,
  input  logic [SW_W-1:0] sw,
  input  logic [BT_W-1:0] bt,
  output logic [SW_W-1:0] switch,
  output logic [BT_W-1:0] button,
  output logic [BT_W-1:0] bt_press,
  output logic            sw_changed
);

  localparam int unsigned N  = SW_W + BT_W;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  if (DEBOUNCE_CYC < 2 || DEBOUNCE_CYC > 65535) begin : g_bad_debounce
    $error("input_debounce: DEBOUNCE_CYC must be in 2..65535");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("input_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_t;

  // Channel order: switches in the low bits, buttons above them.
  logic [N-1:0] meta;
  logic [N-1:0] synced;

  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= {bt, sw};
      synced <= meta;
    end
  end

  deb_state_t    state_q [N];
  deb_state_t    state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [N-1:0]  level_q;
  logic [N-1:0]  level_d;

  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
    end
  end

  // The IDLE->COUNT step does not advance the count, so acceptance lands on
  // the DEBOUNCE_CYC-th edge after the synced bit first differs.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (synced[i] != level_q[i]) begin
            state_d[i] = COUNT;
          end
        end
        COUNT: begin
          if (synced[i] == level_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            level_d[i] = synced[i];
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign switch = level_q[SW_W-1:0];
  assign button = level_q[N-1:SW_W];

  logic [SW_W-1:0] switch_prev;
  logic [BT_W-1:0] button_prev;

  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      switch_prev <= '0;
      button_prev <= '0;
      sw_changed  <= 1'b0;
    end else begin
      switch_prev <= switch;
      button_prev <= button;
      sw_changed  <= |(switch ^ switch_prev);
    end
  end

`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD);

  logic [RW-1:0]   rep_cnt [BT_W];
  logic [BT_W-1:0] rep_started;
  logic [BT_W-1:0] rep_fire;
  logic [BT_W-1:0] button_next;

  assign button_next = level_d[N-1:SW_W];

  // rep_cnt holds the edges elapsed since the last strobe; the press strobe
  // edge counts as 1. Looking at button_next lets a release clear the
  // counter on the same edge the debounced level drops.
  always_comb begin
    rep_fire = '0;
    for (int unsigned i = 0; i < BT_W; i++) begin
      rep_fire[i] = button[i] && button_prev[i] && button_next[i] &&
                    (rep_cnt[i] == (rep_started[i] ? REP_NEXT : REP_FIRST));
    end
  end

  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      for (int unsigned i = 0; i < BT_W; i++) begin
        rep_cnt[i] <= '0;
      end
      rep_started <= '0;
      bt_press    <= '0;
    end else begin
      for (int unsigned i = 0; i < BT_W; i++) begin
        if (!button_next[i]) begin
          rep_cnt[i]     <= '0;
          rep_started[i] <= 1'b0;
        end else if (button[i] && !button_prev[i]) begin
          rep_cnt[i]     <= RW'(1);
          rep_started[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rep_cnt[i]     <= RW'(1);
          rep_started[i] <= 1'b1;
        end else if (button[i]) begin
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
        end
      end
      bt_press <= (button & ~button_prev) | rep_fire;
    end
  end
`else
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      bt_press <= '0;
    end else begin
      bt_press <= button & ~button_prev;
    end
  end
`endif

endmodule
